// File: rtl/seg_shift_sword_pkg.sv
// Shared types and helpers for the seg_shift_sword serial display transmitter.
package seg_shift_sword_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Number of bits needed to represent value (minimum 1).
  function automatic int unsigned GET_WIDTH(input int unsigned value);
    int unsigned w;
    w = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((value >> i) != 0) w = i + 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/seg_shift_sword_clk_tick_gen.sv
// Parameterised divider: one-cycle tick every DIV enabled cycles; count restarts while disabled.
module seg_shift_sword_clk_tick_gen
  import seg_shift_sword_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);

  localparam int unsigned CW = GET_WIDTH(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    tick  = 1'b0;
    if (en) begin
      if (cnt_q == LAST) begin
        tick = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_shift_sword.sv
// Serial transmitter into a 74HC595-style chain: shifts DATA_BITS MSB first, then latches.
// Optional periodic refresh is compiled in with `define AUTO_REFRESH_EN.
module seg_shift_sword
  import seg_shift_sword_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 100,
  parameter int unsigned DATA_BITS  = 64,
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned REFRESH_MS = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 s_dout,
  output logic                 s_clk,
  output logic                 s_latch,
  output logic                 s_clrn
);

  localparam int unsigned BW = GET_WIDTH(DATA_BITS);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [DATA_BITS-1:0] sreg_q, sreg_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 s_clk_q, s_clk_d;
  logic                 s_latch_q, s_latch_d;
  logic                 s_clrn_q, s_clrn_d;
  logic                 phase_en, phase_tick;
  logic                 start_req, accept;

  assign phase_en = (state_q == SHIFT) || (state_q == LATCH);

  seg_shift_sword_clk_tick_gen #(.DIV(CLK_DIV)) u_phase (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (phase_en),
    .tick  (phase_tick)
  );

`ifdef AUTO_REFRESH_EN
  localparam int unsigned REFRESH_CYCLES = CLK_FREQ * REFRESH_MS * 1000;

  logic refresh_tick, pending_q, pending_d;

  seg_shift_sword_clk_tick_gen #(.DIV(REFRESH_CYCLES)) u_refresh (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (1'b1),
    .tick  (refresh_tick)
  );

  // A tick that cannot be served now is remembered once; acceptance consumes it.
  always_comb begin
    pending_d = pending_q;
    if (accept)            pending_d = 1'b0;
    else if (refresh_tick) pending_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= 1'b0;
    else        pending_q <= pending_d;
  end

  assign start_req = start | refresh_tick | pending_q;
`else
  assign start_req = start;
`endif

  assign accept = (state_q == IDLE) && s_clrn_q && start_req;

  always_comb begin
    state_d   = state_q;
    sreg_d    = sreg_q;
    bit_d     = bit_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    s_clk_d   = s_clk_q;
    s_latch_d = s_latch_q;
    s_clrn_d  = 1'b1;
    case (state_q)
      IDLE: begin
        if (accept) begin
          sreg_d  = data;
          bit_d   = '0;
          busy_d  = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (phase_tick) begin
          if (!s_clk_q) begin
            s_clk_d = 1'b1;
          end else begin
            // The final shift empties the register, so s_dout idles at 0.
            s_clk_d = 1'b0;
            sreg_d  = {sreg_q[DATA_BITS-2:0], 1'b0};
            if (bit_q == LAST_BIT) begin
              bit_d     = '0;
              s_latch_d = 1'b1;
              state_d   = LATCH;
            end else begin
              bit_d = bit_q + BW'(1);
            end
          end
        end
      end
      LATCH: begin
        if (phase_tick) begin
          s_latch_d = 1'b0;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      sreg_q    <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      s_clk_q   <= 1'b0;
      s_latch_q <= 1'b0;
      s_clrn_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      sreg_q    <= sreg_d;
      bit_q     <= bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      s_clk_q   <= s_clk_d;
      s_latch_q <= s_latch_d;
      s_clrn_q  <= s_clrn_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign s_dout  = sreg_q[DATA_BITS-1];
  assign s_clk   = s_clk_q;
  assign s_latch = s_latch_q;
  assign s_clrn  = s_clrn_q;

endmodule

// File: tb/tb_seg_shift_sword.sv
// Bench for seg_shift_sword: bit scoreboard checked on every s_clk rise, plus timing checks.
`timescale 1ns/1ps
module tb_seg_shift_sword;

  logic        clk, rst_n;
  logic [63:0] data;
  logic        start;
  logic        busy, done, s_dout, s_clk, s_latch, s_clrn;
  logic [7:0]  data8;
  logic        start8;
  logic        busy8, done8, s_dout8, s_clk8, s_latch8, s_clrn8;

  int checks = 0;
  int failures = 0;
  bit exp_q[$];
  bit exp8_q[$];
  int rises = 0;
  int rises8 = 0;
  logic sclk_prev = 1'b0;
  logic sclk8_prev = 1'b0;
  bit e64, e8;

  seg_shift_sword #(.CLK_FREQ(100), .DATA_BITS(64), .CLK_DIV(2), .REFRESH_MS(1)) dut (
    .clk(clk), .rst_n(rst_n), .data(data), .start(start), .busy(busy), .done(done),
    .s_dout(s_dout), .s_clk(s_clk), .s_latch(s_latch), .s_clrn(s_clrn)
  );

  seg_shift_sword #(.CLK_FREQ(100), .DATA_BITS(8), .CLK_DIV(1), .REFRESH_MS(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .data(data8), .start(start8), .busy(busy8), .done(done8),
    .s_dout(s_dout8), .s_clk(s_clk8), .s_latch(s_latch8), .s_clrn(s_clrn8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each s_clk rise pops one expected bit; a rise with nothing expected is an error.
  always @(negedge clk) begin
    if (s_clk === 1'b1 && sclk_prev !== 1'b1) begin
      rises++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL sdout64_unexpected_rise: rise %0d, no bit expected", rises);
      end else begin
        e64 = exp_q.pop_front();
        if (s_dout !== e64) begin
          failures++;
          $display("FAIL sdout64_bit: rise %0d got %b expected %b", rises, s_dout, e64);
        end
      end
    end
    sclk_prev = s_clk;
    if (s_clk8 === 1'b1 && sclk8_prev !== 1'b1) begin
      rises8++;
      checks++;
      if (exp8_q.size() == 0) begin
        failures++;
        $display("FAIL sdout8_unexpected_rise: rise %0d, no bit expected", rises8);
      end else begin
        e8 = exp8_q.pop_front();
        if (s_dout8 !== e8) begin
          failures++;
          $display("FAIL sdout8_bit: rise %0d got %b expected %b", rises8, s_dout8, e8);
        end
      end
    end
    sclk8_prev = s_clk8;
  end

  task automatic launch(input logic [63:0] d);
    @(negedge clk);
    data  = d;
    start = 1'b1;
    for (int i = 63; i >= 0; i--) exp_q.push_back(d[i]);
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data = '0; start8 = 1'b0; data8 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, s_dout, s_clk, s_latch, s_clrn} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs64: got %b expected 000000", {busy, done, s_dout, s_clk, s_latch, s_clrn});
    end
    checks++;
    if ({busy8, done8, s_dout8, s_clk8, s_latch8, s_clrn8} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs8: got %b expected 000000", {busy8, done8, s_dout8, s_clk8, s_latch8, s_clrn8});
    end
    @(negedge clk);
    rst_n = 1'b1;
    start = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_clrn !== 1'b1 || s_clrn8 !== 1'b1) begin
      failures++;
      $display("FAIL clrn_release: got %b%b expected 11", s_clrn, s_clrn8);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_while_clearing: busy got %b expected 0", busy);
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL start_not_queued_after_clear: busy got %b expected 0", busy);
    end
  endtask

  task automatic test_single();
    int done_at = -1;
    int latch_cycles = 0;
    rises = 0;
    launch(64'h8000_0000_0000_0001);
    checks++;
    if (busy !== 1'b1 || s_dout !== 1'b1) begin
      failures++;
      $display("FAIL single_load: busy,s_dout got %b%b expected 11", busy, s_dout);
    end
    for (int k = 1; k <= 400 && done_at < 0; k++) begin
      @(posedge clk);
      #1;
      if (s_latch === 1'b1) latch_cycles++;
      if (done === 1'b1) done_at = k;
    end
    checks++;
    if (done_at != 258) begin
      failures++;
      $display("FAIL single_done_latency: got %0d expected 258", done_at);
    end
    checks++;
    if (rises != 64) begin
      failures++;
      $display("FAIL single_rises: got %0d expected 64", rises);
    end
    checks++;
    if (latch_cycles != 2) begin
      failures++;
      $display("FAIL single_latch_width: got %0d expected 2", latch_cycles);
    end
    checks++;
    if (busy !== 1'b0 || s_dout !== 1'b0) begin
      failures++;
      $display("FAIL single_busy_at_done: busy,s_dout got %b%b expected 00", busy, s_dout);
    end
    @(posedge clk);
    #1;
    checks++;
    if (done !== 1'b0) begin
      failures++;
      $display("FAIL single_done_pulse: got %b expected 0", done);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL single_leftover_bits: got %0d expected 0", exp_q.size());
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] d = 64'hC3A5_0F1E_2D3C_4B5A;
    int done_t[2] = '{-1, -1};
    int n_done = 0;
    logic busy259 = 1'bx;
    logic busy260 = 1'bx;
    rises = 0;
    @(negedge clk);
    data  = d;
    start = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int i = 63; i >= 0; i--) exp_q.push_back(d[i]);
    @(posedge clk);
    #1;
    for (int k = 1; k <= 600; k++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        if (n_done < 2) done_t[n_done] = k;
        n_done++;
      end
      if (k == 259) busy259 = busy;
      if (k == 260) begin
        busy260 = busy;
        start = 1'b0;
      end
    end
    checks++;
    if (done_t[0] != 258 || done_t[1] != 518) begin
      failures++;
      $display("FAIL b2b_done_times: got %0d,%0d expected 258,518", done_t[0], done_t[1]);
    end
    checks++;
    if (n_done != 2) begin
      failures++;
      $display("FAIL b2b_frame_count: got %0d expected 2", n_done);
    end
    checks++;
    if (busy259 !== 1'b0 || busy260 !== 1'b1) begin
      failures++;
      $display("FAIL b2b_idle_gap: busy@259,260 got %b%b expected 01", busy259, busy260);
    end
    checks++;
    if (rises != 128) begin
      failures++;
      $display("FAIL b2b_rises: got %0d expected 128", rises);
    end
  endtask

  task automatic test_ignore_midframe();
    logic [63:0] d1 = 64'h0123_4567_89AB_CDEF;
    int done_at = -1;
    int busy_seen = 0;
    rises = 0;
    launch(d1);
    for (int k = 1; k <= 400 && done_at < 0; k++) begin
      @(posedge clk);
      #1;
      if (k == 10) data = ~d1;
      if (k == 50) start = 1'b1;
      if (k == 51) start = 1'b0;
      if (done === 1'b1) done_at = k;
    end
    checks++;
    if (done_at != 258) begin
      failures++;
      $display("FAIL ignore_done_latency: got %0d expected 258", done_at);
    end
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy !== 1'b0) busy_seen++;
    end
    checks++;
    if (busy_seen != 0 || rises != 64) begin
      failures++;
      $display("FAIL ignore_no_queued_frame: busy cycles %0d rises %0d expected 0 and 64", busy_seen, rises);
    end
  endtask

  task automatic test_reset_midframe();
    int r0;
    rises = 0;
    launch(64'hFFFF_0000_FFFF_0000);
    repeat (102) @(posedge clk);
    #1;
    checks++;
    if (s_clk !== 1'b1 || busy !== 1'b1) begin
      failures++;
      $display("FAIL midreset_precondition: s_clk,busy got %b%b expected 11", s_clk, busy);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, s_dout, s_clk, s_latch, s_clrn} !== 6'b0) begin
      failures++;
      $display("FAIL midreset_async_clear: got %b expected 000000", {busy, done, s_dout, s_clk, s_latch, s_clrn});
    end
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (s_clrn !== 1'b1) begin
      failures++;
      $display("FAIL midreset_clrn_release: got %b expected 1", s_clrn);
    end
    r0 = rises;
    repeat (300) @(posedge clk);
    #1;
    checks++;
    if (rises != r0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet: rises %0d busy %b expected %0d and 0", rises, busy, r0);
    end
  endtask

  task automatic test_small_config();
    logic [7:0] d = 8'hA5;
    int done_at = -1;
    int latch_cycles = 0;
    rises8 = 0;
    @(negedge clk);
    data8  = d;
    start8 = 1'b1;
    for (int i = 7; i >= 0; i--) exp8_q.push_back(d[i]);
    @(posedge clk);
    #1;
    start8 = 1'b0;
    checks++;
    if (busy8 !== 1'b1 || s_dout8 !== 1'b1) begin
      failures++;
      $display("FAIL small_load: busy,s_dout got %b%b expected 11", busy8, s_dout8);
    end
    for (int k = 1; k <= 60 && done_at < 0; k++) begin
      @(posedge clk);
      #1;
      if (s_latch8 === 1'b1) latch_cycles++;
      if (done8 === 1'b1) done_at = k;
    end
    checks++;
    if (done_at != 17) begin
      failures++;
      $display("FAIL small_done_latency: got %0d expected 17", done_at);
    end
    checks++;
    if (rises8 != 8 || exp8_q.size() != 0) begin
      failures++;
      $display("FAIL small_rises: got %0d (left %0d) expected 8 (left 0)", rises8, exp8_q.size());
    end
    checks++;
    if (latch_cycles != 1) begin
      failures++;
      $display("FAIL small_latch_width: got %0d expected 1", latch_cycles);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_ignore_midframe();
    test_reset_midframe();
    test_small_config();
    repeat (5) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
